// File: rtl/frame_pkg.sv
// Shared constants and types for the frame spill stack.
package frame_pkg;

    localparam int WORD_W      = 16;
    localparam int FRAME_WORDS = 16;
    localparam int FRAME_W     = WORD_W * FRAME_WORDS;

    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        LOAD,
        LWAIT,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_SAVE,
        OP_LOAD
    } op_e;

endpackage

// File: rtl/spill_ram.sv
// Single-port word RAM: synchronous write, registered 1-cycle read.
module spill_ram
    import frame_pkg::*;
#(
    parameter  int FRAMES = 8,
    localparam int AW     = $clog2(FRAMES * FRAME_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [FRAMES*FRAME_WORDS];
    logic [WORD_W-1:0] rdata_q;

    // Contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/frame_spill.sv
// Register-file frame stack spilling 256-bit frames to a word RAM.
// Define FRAME_SPILL_ERR_EN to add the sticky err port.
module frame_spill
    import frame_pkg::*;
#(
    parameter int FRAMES = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [FRAME_W-1:0]      fcOut,
    input  logic                    save_req,
    input  logic                    load_req,
    output logic [FRAME_W-1:0]      fcIn,
    output logic                    restore,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(FRAMES):0] depth
`ifdef FRAME_SPILL_ERR_EN
    ,
    output logic                    err
`endif
);

    localparam int DW = $clog2(FRAMES) + 1;
    localparam int FW = DW - 1;
    localparam int CW = $clog2(FRAME_WORDS);
    localparam int AW = FW + CW;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DW-1:0]      depth_q, depth_d;
    logic [FRAME_W-1:0] sreg_q, sreg_d;
    logic [FRAME_W-1:0] fcin_q, fcin_d;
    logic               err_q, err_d;

    logic               full, empty, last;
    logic [DW-1:0]      fidx;
    logic               ram_we;
    logic [AW-1:0]      ram_addr;
    logic [WORD_W-1:0]  ram_rdata;

    assign full  = depth_q == DW'(FRAMES);
    assign empty = depth_q == '0;
    assign last  = cnt_q == CW'(FRAME_WORDS - 1);
    assign fidx  = (op_q == OP_LOAD) ? depth_q - DW'(1) : depth_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            cnt_q   <= '0;
            depth_q <= '0;
            sreg_q  <= '0;
            fcin_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            depth_q <= depth_d;
            sreg_q  <= sreg_d;
            fcin_q  <= fcin_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (save_req) begin
                    state_d = full ? DONE : SAVE;
                end else if (load_req) begin
                    state_d = empty ? DONE : LOAD;
                end
            end
            SAVE:    if (last) state_d = DONE;
            LOAD:    if (last) state_d = LWAIT;
            LWAIT:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_d    = op_q;
        cnt_d   = cnt_q;
        depth_d = depth_q;
        sreg_d  = sreg_q;
        fcin_d  = fcin_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (save_req) begin
                    op_d   = full ? OP_NOP : OP_SAVE;
                    sreg_d = fcOut;
                    err_d  = err_q | full;
                end else if (load_req) begin
                    op_d  = empty ? OP_NOP : OP_LOAD;
                    err_d = err_q | empty;
                end
            end
            SAVE: begin
                cnt_d  = cnt_q + CW'(1);
                sreg_d = sreg_q >> WORD_W;
                if (last) depth_d = depth_q + DW'(1);
            end
            LOAD: begin
                cnt_d = cnt_q + CW'(1);
                // First LOAD cycle has no read data yet.
                if (cnt_q != '0) begin
                    sreg_d = {ram_rdata, sreg_q[FRAME_W-1:WORD_W]};
                end
            end
            LWAIT: begin
                fcin_d  = {ram_rdata, sreg_q[FRAME_W-1:WORD_W]};
                depth_d = depth_q - DW'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        busy     = state_q != IDLE;
        done     = state_q == DONE;
        restore  = (state_q == DONE) && (op_q == OP_LOAD);
        ram_we   = state_q == SAVE;
        ram_addr = {fidx[FW-1:0], cnt_q};
    end

    spill_ram #(
        .FRAMES (FRAMES)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (sreg_q[WORD_W-1:0]),
        .rdata (ram_rdata)
    );

    assign fcIn  = fcin_q;
    assign depth = depth_q;
`ifdef FRAME_SPILL_ERR_EN
    assign err   = err_q;
`endif

endmodule

// File: tb/tb_frame_spill.sv
// Directed + random bench for frame_spill against a stack model.
module tb_frame_spill;

    localparam int FRAMES = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] fcOut;
    logic         save_req;
    logic         load_req;
    logic [255:0] fcIn;
    logic         restore;
    logic         busy;
    logic         done;
    logic [3:0]   depth;
`ifdef FRAME_SPILL_ERR_EN
    logic         err;
`endif

    frame_spill #(.FRAMES(FRAMES)) dut (
        .clk      (clk),
        .reset    (reset),
        .fcOut    (fcOut),
        .save_req (save_req),
        .load_req (load_req),
        .fcIn     (fcIn),
        .restore  (restore),
        .busy     (busy),
        .done     (done),
        .depth    (depth)
`ifdef FRAME_SPILL_ERR_EN
        ,
        .err      (err)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [255:0] stk[$];
    logic [255:0] fcin_m;
    bit           err_m;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd_frame();
        logic [255:0] f;
        for (int i = 0; i < 8; i++) f[32*i +: 32] = $urandom;
        return f;
    endfunction

    task automatic chk_state(input string tag);
        chk({tag, "_depth"}, 256'(depth), 256'(stk.size()));
        chk({tag, "_fcin"}, fcIn, fcin_m);
`ifdef FRAME_SPILL_ERR_EN
        chk({tag, "_err"}, 256'(err), 256'(err_m));
`endif
    endtask

    // Called #1 after a rising edge with the DUT idle.
    task automatic run_op(input string tag, input bit s, input bit l,
                          input logic [255:0] data);
        int  exp_done, exp_rst, done_c, rst_c, idle_c, ndone;
        bit  nop_op, is_load;
        nop_op  = 0;
        is_load = 0;
        if (s) begin
            if (stk.size() == FRAMES) begin
                nop_op = 1;
                err_m  = 1;
            end else begin
                stk.push_back(data);
            end
        end else if (l) begin
            if (stk.size() == 0) begin
                nop_op = 1;
                err_m  = 1;
            end else begin
                fcin_m  = stk.pop_back();
                is_load = 1;
            end
        end
        exp_done = nop_op ? 1 : (is_load ? 18 : 17);
        exp_rst  = is_load ? 18 : 0;

        save_req = s;
        load_req = l;
        fcOut    = data;
        @(posedge clk);
        #1;
        save_req = 0;
        load_req = 0;
        fcOut    = rnd_frame();
        done_c = 0;
        rst_c  = 0;
        idle_c = 0;
        ndone  = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                ndone++;
                if (done_c == 0) done_c = c;
            end
            if (restore) rst_c = (rst_c == 0) ? c : -1;
            if (!busy) begin
                idle_c = c;
                break;
            end
            @(posedge clk);
            #1;
            fcOut = rnd_frame();
        end
        chk({tag, "_done_cyc"}, 256'(done_c), 256'(exp_done));
        chk({tag, "_idle_cyc"}, 256'(idle_c), 256'(exp_done + 1));
        chk({tag, "_ndone"}, 256'(ndone), 256'(1));
        chk({tag, "_rst_cyc"}, 256'(rst_c), 256'(exp_rst));
        chk_state(tag);
    endtask

    initial begin
        logic [255:0] pat;
        int           rc;
        bit           rst_seen;

        reset    = 1;
        save_req = 0;
        load_req = 0;
        fcOut    = '0;
        fcin_m   = '0;
        err_m    = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_restore", 256'(restore), 256'(0));
        chk_state("rst");

        for (int i = 0; i < 16; i++) pat[16*i +: 16] = 16'(16'h1000 + i);
        run_op("save_pat", 1, 0, pat);
        run_op("load_pat", 0, 1, rnd_frame());

        run_op("save_a", 1, 0, rnd_frame());
        run_op("save_b", 1, 0, rnd_frame());
        run_op("load_b", 0, 1, rnd_frame());
        run_op("load_a", 0, 1, rnd_frame());

        run_op("under", 0, 1, rnd_frame());

        for (int i = 0; i < FRAMES; i++) run_op("fill", 1, 0, rnd_frame());
        run_op("over", 1, 0, rnd_frame());
        for (int i = 0; i < FRAMES; i++) run_op("drain", 0, 1, rnd_frame());

        run_op("one", 1, 0, rnd_frame());
        run_op("both", 1, 1, rnd_frame());

        for (int i = 0; i < 40; i++) begin
            int k;
            k = $urandom_range(0, 2);
            run_op("rand", k != 1, k != 0, rnd_frame());
        end

        if (stk.size() == 0) run_op("pre_abort", 1, 0, rnd_frame());
        load_req = 1;
        @(posedge clk);
        #1;
        load_req = 0;
        rst_seen = 0;
        for (rc = 1; rc < 8; rc++) begin
            if (restore) rst_seen = 1;
            @(posedge clk);
            #1;
        end
        if (restore) rst_seen = 1;
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        stk.delete();
        fcin_m = '0;
        err_m  = 0;
        for (int i = 0; i < 3; i++) begin
            if (restore) rst_seen = 1;
            @(posedge clk);
            #1;
        end
        chk("abort_restore", 256'(rst_seen), 256'(0));
        chk("abort_busy", 256'(busy), 256'(0));
        chk("abort_done", 256'(done), 256'(0));
        chk_state("abort");

        run_op("post_save", 1, 0, rnd_frame());
        run_op("post_load", 0, 1, rnd_frame());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
